// File: rtl/led_rotation_monitor.sv
// Watches a rotating one-hot LED vector: locks onto it, counts full rotations and flags mismatches.
// Optional macro LED_MON_BIDIR_EN also accepts right rotation, with the direction latched at the first step.
module led_rotation_monitor #(
   parameter int NB_LEDS  = 4,
   parameter int NB_COUNT = 8
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic [NB_LEDS-1:0]  i_led,
   input  logic                i_sample,
   input  logic                i_clear,
   output logic                o_locked,
   output logic                o_error,
   output logic                o_fault,
   output logic [NB_COUNT-1:0] o_rot_count,
   output logic [NB_COUNT-1:0] o_err_count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_FAULT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [NB_LEDS-1:0]  prev_q, prev_d;
   logic                error_q, error_d;
   logic                locked_q, fault_q;
   logic [NB_COUNT-1:0] rot_q, rot_d;
   logic [NB_COUNT-1:0] errc_q, errc_d;

   logic               led_onehot;
   logic [NB_LEDS-1:0] prev_rotl;
   logic               step_left;

   function automatic logic [NB_COUNT-1:0] sat_inc(input logic [NB_COUNT-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign led_onehot = (i_led != '0) && ((i_led & (i_led - 1'b1)) == '0);
   assign prev_rotl  = {prev_q[NB_LEDS-2:0], prev_q[NB_LEDS-1]};

`ifdef LED_MON_BIDIR_EN
   // dir_q: 0 = left, 1 = right; only meaningful once dir_valid_q is set
   logic               dir_valid_q, dir_valid_d;
   logic               dir_q, dir_d;
   logic [NB_LEDS-1:0] prev_rotr;
   logic               step_right;

   assign prev_rotr  = {prev_q[0], prev_q[NB_LEDS-1:1]};
   assign step_left  = (i_led == prev_rotl) && (!dir_valid_q || !dir_q);
   assign step_right = (i_led == prev_rotr) && (!dir_valid_q || dir_q);
`else
   assign step_left  = (i_led == prev_rotl);
`endif

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      error_d = error_q;
      rot_d   = rot_q;
      errc_d  = errc_q;
`ifdef LED_MON_BIDIR_EN
      dir_valid_d = dir_valid_q;
      dir_d       = dir_q;
`endif
      if (i_clear) begin
         state_d = ST_IDLE;
         prev_d  = '0;
         error_d = 1'b0;
         rot_d   = '0;
         errc_d  = '0;
`ifdef LED_MON_BIDIR_EN
         dir_valid_d = 1'b0;
         dir_d       = 1'b0;
`endif
      end else if (i_sample) begin
         case (state_q)
            ST_IDLE: begin
               if (led_onehot) begin
                  prev_d  = i_led;
                  state_d = ST_LOCKED;
`ifdef LED_MON_BIDIR_EN
                  dir_valid_d = 1'b0;
`endif
               end
            end
            ST_LOCKED: begin
               if (!led_onehot) begin
                  error_d = 1'b1;
                  errc_d  = sat_inc(errc_q);
                  state_d = ST_FAULT;
               end else if (i_led == prev_q) begin
                  // hold: the shift register has not advanced yet
               end else if (step_left) begin
                  prev_d = i_led;
                  if (i_led[0]) rot_d = sat_inc(rot_q);
`ifdef LED_MON_BIDIR_EN
                  dir_valid_d = 1'b1;
                  dir_d       = 1'b0;
               end else if (step_right) begin
                  prev_d = i_led;
                  if (i_led[NB_LEDS-1]) rot_d = sat_inc(rot_q);
                  dir_valid_d = 1'b1;
                  dir_d       = 1'b1;
`endif
               end else begin
                  error_d = 1'b1;
                  errc_d  = sat_inc(errc_q);
                  prev_d  = i_led;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= ST_IDLE;
         prev_q   <= '0;
         error_q  <= 1'b0;
         locked_q <= 1'b0;
         fault_q  <= 1'b0;
         rot_q    <= '0;
         errc_q   <= '0;
`ifdef LED_MON_BIDIR_EN
         dir_valid_q <= 1'b0;
         dir_q       <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         error_q  <= error_d;
         locked_q <= (state_d == ST_LOCKED);
         fault_q  <= (state_d == ST_FAULT);
         rot_q    <= rot_d;
         errc_q   <= errc_d;
`ifdef LED_MON_BIDIR_EN
         dir_valid_q <= dir_valid_d;
         dir_q       <= dir_d;
`endif
      end
   end

   assign o_locked    = locked_q;
   assign o_error     = error_q;
   assign o_fault     = fault_q;
   assign o_rot_count = rot_q;
   assign o_err_count = errc_q;

endmodule

// File: tb/tb_led_rotation_monitor.sv
// Directed bench for led_rotation_monitor (NB_LEDS=4, NB_COUNT=8) with hand-computed expectations.
module tb_led_rotation_monitor;

   logic       clock = 1'b0;
   logic       i_reset;
   logic [3:0] i_led;
   logic       i_sample;
   logic       i_clear;
   logic       o_locked, o_error, o_fault;
   logic [7:0] o_rot_count, o_err_count;

   int n_vec = 0;
   int n_bad = 0;

   led_rotation_monitor #(.NB_LEDS(4), .NB_COUNT(8)) dut (
      .clock       (clock),
      .i_reset     (i_reset),
      .i_led       (i_led),
      .i_sample    (i_sample),
      .i_clear     (i_clear),
      .o_locked    (o_locked),
      .o_error     (o_error),
      .o_fault     (o_fault),
      .o_rot_count (o_rot_count),
      .o_err_count (o_err_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // drive one cycle of inputs, then settle just after the capturing edge
   task automatic apply(input logic [3:0] led, input logic smp, input logic clr);
      i_led    = led;
      i_sample = smp;
      i_clear  = clr;
      @(posedge clock);
      #1;
      i_sample = 1'b0;
      i_clear  = 1'b0;
   endtask

   task automatic smp(input logic [3:0] led);
      apply(led, 1'b1, 1'b0);
   endtask

   task automatic chk_all(input string tag, input logic lk, input logic er, input logic ft,
                          input logic [7:0] rc, input logic [7:0] ec);
      chk({tag, ".locked"}, {31'd0, o_locked}, {31'd0, lk});
      chk({tag, ".error"},  {31'd0, o_error},  {31'd0, er});
      chk({tag, ".fault"},  {31'd0, o_fault},  {31'd0, ft});
      chk({tag, ".rot"},    {24'd0, o_rot_count}, {24'd0, rc});
      chk({tag, ".err"},    {24'd0, o_err_count}, {24'd0, ec});
   endtask

   initial begin
      i_reset  = 1'b0;
      i_led    = 4'b0000;
      i_sample = 1'b0;
      i_clear  = 1'b0;
      #3;
      chk_all("reset", 0, 0, 0, 8'd0, 8'd0);
      #9 i_reset = 1'b1;
      @(posedge clock);
      #1;

      // clean rotation, lock visible one cycle after the first sample
      smp(4'b0001);
      chk("lock_first", {31'd0, o_locked}, 32'd1);
      smp(4'b0010); smp(4'b0100); smp(4'b1000); smp(4'b0001);
      chk_all("rot1", 1, 0, 0, 8'd1, 8'd0);

      // skip from 0010 to 1000 re-anchors, next 0001 is clean and wraps
      smp(4'b0010);
      smp(4'b1000);
      chk_all("skip", 1, 1, 0, 8'd1, 8'd1);
      smp(4'b0001);
      chk_all("reanchor", 1, 1, 0, 8'd2, 8'd1);

      // unqualified garbage is ignored
      apply(4'b0110, 1'b0, 1'b0);
      chk_all("nosample", 1, 1, 0, 8'd2, 8'd1);

      // hold repeats are not errors
      smp(4'b0010); smp(4'b0100); smp(4'b0100);
      chk_all("hold", 1, 1, 0, 8'd2, 8'd1);

      // multi-hot -> FAULT, then samples ignored until clear
      smp(4'b0110);
      chk_all("fault", 0, 1, 1, 8'd2, 8'd2);
      smp(4'b1000); smp(4'b0001);
      chk_all("fault_ign", 0, 1, 1, 8'd2, 8'd2);
      apply(4'b0000, 1'b0, 1'b1);
      chk_all("clear", 0, 0, 0, 8'd0, 8'd0);

      // zero sample while locked also faults
      smp(4'b0100); smp(4'b0000);
      chk_all("zero", 0, 1, 1, 8'd0, 8'd1);
      apply(4'b0000, 1'b0, 1'b1);

      // rotation counter saturates
      smp(4'b0001);
      for (int r = 0; r < 1030; r++) begin
         smp(4'b0010); smp(4'b0100); smp(4'b1000); smp(4'b0001);
      end
      chk_all("rot_sat", 1, 0, 0, 8'd255, 8'd0);
      smp(4'b0010); smp(4'b0100); smp(4'b0100);
      chk_all("sat_hold", 1, 0, 0, 8'd255, 8'd0);

      // error counter saturates: 0100<->0001 alternation is a mismatch every sample
      for (int r = 0; r < 150; r++) begin
         smp(4'b0001); smp(4'b0100);
      end
      chk_all("err_sat", 1, 1, 0, 8'd255, 8'd255);

      // asynchronous reset mid-rotation
      apply(4'b0000, 1'b0, 1'b1);
      smp(4'b0001);
      for (int r = 0; r < 5; r++) begin
         smp(4'b0010); smp(4'b0100); smp(4'b1000); smp(4'b0001);
      end
      chk("rot5", {24'd0, o_rot_count}, 32'd5);
      #2 i_reset = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 8'd0, 8'd0);
      #2 i_reset = 1'b1;
      @(posedge clock);
      #1;
      // history gone: 0010 is a fresh lock, not a step from 0001
      smp(4'b0010);
      smp(4'b0100);
      chk_all("post_rst", 1, 0, 0, 8'd0, 8'd0);

      // clear beats sample in the same cycle
      apply(4'b1000, 1'b1, 1'b1);
      chk_all("clr_lock", 0, 0, 0, 8'd0, 8'd0);
      apply(4'b0001, 1'b1, 1'b1);
      chk_all("clr_idle", 0, 0, 0, 8'd0, 8'd0);

      // right-going sequence
      smp(4'b1000); smp(4'b0100); smp(4'b0010); smp(4'b0001); smp(4'b1000);
`ifdef LED_MON_BIDIR_EN
      chk_all("rotr", 1, 0, 0, 8'd1, 8'd0);
      // opposite direction after latching right is a mismatch
      smp(4'b0001);
      chk_all("rotr_opp", 1, 1, 0, 8'd1, 8'd1);
`else
      chk_all("rotr", 1, 1, 0, 8'd0, 8'd4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
